// File: rtl/id_hazard_scoreboard_if.sv
// Decode-stage hazard scoreboard bus: ID-side register usage and pipeline controls
// in, per-port hazard flags and stall request out.
interface id_hazard_scoreboard_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_READ_PORTS = 2
);
  logic                                     pipe_advance;
  logic                                     flush;
  logic [NUM_READ_PORTS-1:0]                read_en;
  logic [NUM_READ_PORTS*REG_ADDR_WIDTH-1:0] read_addr;
  logic                                     issue_valid;
  logic                                     issue_write_en;
  logic [REG_ADDR_WIDTH-1:0]                issue_write_addr;
  logic [1:0]                               issue_lat_sel;
  logic [NUM_READ_PORTS-1:0]                read_related;
  logic                                     stall_request;
  logic                                     any_pending;

  modport master (
    output pipe_advance, flush, read_en, read_addr,
           issue_valid, issue_write_en, issue_write_addr, issue_lat_sel,
    input  read_related, stall_request, any_pending
  );

  modport slave (
    input  pipe_advance, flush, read_en, read_addr,
           issue_valid, issue_write_en, issue_write_addr, issue_lat_sel,
    output read_related, stall_request, any_pending
  );
endinterface

// File: rtl/id_hazard_scoreboard.sv
// Per-register remaining-latency scoreboard for the decode stage: flags reads of
// registers whose producer cannot forward yet and requests a decode stall.
module id_hazard_scoreboard #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_READ_PORTS = 2,
  parameter int LOAD_LATENCY   = 1,
  parameter int LONG_LATENCY   = 4,
  parameter int CNT_WIDTH      = 3
) (
  input logic                    clk,
  input logic                    rst,
  id_hazard_scoreboard_if.slave  sb
);
  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LOAD_CNT = CNT_WIDTH'(LOAD_LATENCY);
  localparam logic [CNT_WIDTH-1:0] LONG_CNT = CNT_WIDTH'(LONG_LATENCY);

  logic [CNT_WIDTH-1:0]      cnt [NUM_REGS];
  logic [NUM_READ_PORTS-1:0] read_related;
  logic                      stall_request;
  logic                      any_pending;
  logic                      issue_hit;
  logic [CNT_WIDTH-1:0]      issue_cnt;

  // Hazard flags look at pre-update counters, so an instruction never stalls on itself.
  always_comb begin
    read_related = '0;
    for (int i = 0; i < NUM_READ_PORTS; i++) begin
      read_related[i] = sb.read_en[i]
                     && (sb.read_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] != '0)
                     && (cnt[sb.read_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]] != '0);
    end
  end

  always_comb begin
    any_pending = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      any_pending = any_pending | (cnt[r] != '0);
    end
  end

  assign stall_request = |read_related;

  always_comb begin
    case (sb.issue_lat_sel)
      2'd1:    issue_cnt = LOAD_CNT;
      2'd2:    issue_cnt = LONG_CNT;
      default: issue_cnt = '0;
    endcase
  end

  assign issue_hit = sb.issue_valid && sb.pipe_advance && !stall_request && !sb.flush
                  && sb.issue_write_en && (sb.issue_write_addr != '0);

  // Register 0 is only ever written by reset, so its counter stays zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else if (sb.flush) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else if (sb.pipe_advance) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (issue_hit && (sb.issue_write_addr == REG_ADDR_WIDTH'(r))) begin
          cnt[r] <= issue_cnt;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - CNT_WIDTH'(1);
        end
      end
    end
  end

  assign sb.read_related  = read_related;
  assign sb.stall_request = stall_request;
  assign sb.any_pending   = any_pending;
endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Self-checking bench for id_hazard_scoreboard: directed scenarios with literal
// expectations plus randomized traffic checked against a ready-time model.
module tb_id_hazard_scoreboard;
  localparam int W     = 5;
  localparam int NP    = 2;
  localparam int NREGS = 2 ** W;
  localparam int LOAD_LAT = 1;
  localparam int LONG_LAT = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  // Model: a register is pending while its ready point lies ahead of the advance count.
  longint ready_at [NREGS];
  longint adv;

  id_hazard_scoreboard_if #(.REG_ADDR_WIDTH(W), .NUM_READ_PORTS(NP)) sb_if ();

  id_hazard_scoreboard #(
    .REG_ADDR_WIDTH(W), .NUM_READ_PORTS(NP),
    .LOAD_LATENCY(LOAD_LAT), .LONG_LATENCY(LONG_LAT), .CNT_WIDTH(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit pend(int r);
    return (r != 0) && (ready_at[r] > adv);
  endfunction

  function automatic int port_addr(int i);
    logic [NP*W-1:0] all;
    all = sb_if.read_addr;
    return int'(all[i*W +: W]);
  endfunction

  function automatic logic [NP-1:0] model_rr();
    logic [NP-1:0] rr;
    rr = '0;
    for (int i = 0; i < NP; i++) rr[i] = sb_if.read_en[i] && pend(port_addr(i));
    return rr;
  endfunction

  function automatic bit model_any();
    bit a;
    a = 1'b0;
    for (int r = 0; r < NREGS; r++) a = a | pend(r);
    return a;
  endfunction

  function automatic longint lat_of(logic [1:0] sel);
    case (sel)
      2'd1:    return longint'(LOAD_LAT);
      2'd2:    return longint'(LONG_LAT);
      default: return 0;
    endcase
  endfunction

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model compare at negedge, model step at posedge, every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        adv = 0;
        for (int r = 0; r < NREGS; r++) ready_at[r] = 0;
      end
      check_val("model_read_related", 32'(sb_if.read_related), 32'(model_rr()));
      check_val("model_stall_request", 32'(sb_if.stall_request), 32'(|model_rr()));
      check_val("model_any_pending", 32'(sb_if.any_pending), 32'(model_any()));
      @(posedge clk);
      if (!rst) begin
        adv = 0;
        for (int r = 0; r < NREGS; r++) ready_at[r] = 0;
      end else if (sb_if.flush) begin
        for (int r = 0; r < NREGS; r++) ready_at[r] = adv;
      end else if (sb_if.pipe_advance) begin
        bit accept;
        accept = sb_if.issue_valid && !(|model_rr());
        adv++;
        if (accept && sb_if.issue_write_en && sb_if.issue_write_addr != '0)
          ready_at[int'(sb_if.issue_write_addr)] = adv + lat_of(sb_if.issue_lat_sel);
      end
    end
  end

  task automatic apply_stimulus(input bit pa, input bit fl, input bit [1:0] ren,
                                input int a0, input int a1, input bit iv, input bit iw,
                                input int ia, input bit [1:0] lat);
    @(posedge clk);
    #1;
    sb_if.pipe_advance     = pa;
    sb_if.flush            = fl;
    sb_if.read_en          = ren;
    sb_if.read_addr        = {W'(a1), W'(a0)};
    sb_if.issue_valid      = iv;
    sb_if.issue_write_en   = iw;
    sb_if.issue_write_addr = W'(ia);
    sb_if.issue_lat_sel    = lat;
  endtask

  task automatic apply_random(input int amax);
    apply_stimulus($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
                   2'($urandom), $urandom_range(0, amax), $urandom_range(0, amax),
                   $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8,
                   $urandom_range(0, amax), 2'($urandom));
  endtask

  task automatic idle();
    apply_stimulus(1, 0, 2'b00, 0, 0, 0, 0, 0, 2'd0);
  endtask

  task automatic check_output(input string name, input logic [1:0] rr, input bit sr, input bit ap);
    @(negedge clk);
    check_val({name, "_rr"}, 32'(sb_if.read_related), 32'(rr));
    check_val({name, "_sr"}, 32'(sb_if.stall_request), 32'(sr));
    check_val({name, "_ap"}, 32'(sb_if.any_pending), 32'(ap));
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b0;
    sb_if.pipe_advance = 1'b0;
    sb_if.flush = 1'b0;
    sb_if.read_en = '0;
    sb_if.read_addr = '0;
    sb_if.issue_valid = 1'b0;
    sb_if.issue_write_en = 1'b0;
    sb_if.issue_write_addr = '0;
    sb_if.issue_lat_sel = '0;

    for (int k = 0; k < 4; k++) begin
      apply_random(31);
      check_output("in_reset", 2'b00, 0, 0);
    end
    idle();
    rst = 1'b1;
    check_output("after_reset", 2'b00, 0, 0);

    // Load r5, then back-to-back consumer on port 0 stalls exactly one cycle.
    apply_stimulus(1, 0, 2'b00, 0, 0, 1, 1, 5, 2'd1);
    check_output("load_issue", 2'b00, 0, 0);
    apply_stimulus(1, 0, 2'b01, 5, 0, 1, 0, 0, 2'd0);
    check_output("load_stall", 2'b01, 1, 1);
    apply_stimulus(1, 0, 2'b01, 5, 0, 1, 0, 0, 2'd0);
    check_output("load_clear", 2'b00, 0, 0);

    // Long op to r8 read on port 1; pipeline frozen for 3 cycles stretches it to 7.
    apply_stimulus(1, 0, 2'b00, 0, 0, 1, 1, 8, 2'd2);
    check_output("long_issue", 2'b00, 0, 0);
    for (int k = 0; k < 7; k++) begin
      apply_stimulus((k == 0 || k > 3), 0, 2'b10, 0, 8, 1, 0, 0, 2'd0);
      check_output("long_stall", 2'b10, 1, 1);
    end
    apply_stimulus(1, 0, 2'b10, 0, 8, 1, 0, 0, 2'd0);
    check_output("long_clear", 2'b00, 0, 0);

    // ALU write to r3 clears a pending load.
    apply_stimulus(1, 0, 2'b00, 0, 0, 1, 1, 3, 2'd1);
    check_output("ovr_load", 2'b00, 0, 0);
    apply_stimulus(1, 0, 2'b01, 2, 0, 1, 1, 3, 2'd0);
    check_output("ovr_alu", 2'b00, 0, 1);
    apply_stimulus(1, 0, 2'b01, 3, 0, 1, 0, 0, 2'd0);
    check_output("ovr_alu_read", 2'b00, 0, 0);

    // Long write to r3 over a pending load: youngest writer wins.
    apply_stimulus(1, 0, 2'b00, 0, 0, 1, 1, 3, 2'd1);
    check_output("ovr2_load", 2'b00, 0, 0);
    apply_stimulus(1, 0, 2'b01, 1, 0, 1, 1, 3, 2'd2);
    check_output("ovr2_long", 2'b00, 0, 1);
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1, 0, 2'b01, 3, 0, 1, 0, 0, 2'd0);
      check_output("ovr2_stall", 2'b01, 1, 1);
    end
    apply_stimulus(1, 0, 2'b01, 3, 0, 1, 0, 0, 2'd0);
    check_output("ovr2_clear", 2'b00, 0, 0);

    // r0 never tracked; port independence.
    apply_stimulus(1, 0, 2'b00, 0, 0, 1, 1, 0, 2'd1);
    check_output("r0_load", 2'b00, 0, 0);
    apply_stimulus(1, 0, 2'b11, 0, 0, 1, 0, 0, 2'd0);
    check_output("r0_read", 2'b00, 0, 0);
    apply_stimulus(1, 0, 2'b00, 0, 0, 1, 1, 7, 2'd1);
    check_output("r7_load", 2'b00, 0, 0);
    apply_stimulus(1, 0, 2'b11, 2, 7, 1, 0, 0, 2'd0);
    check_output("r7_port1", 2'b10, 1, 1);
    idle();
    check_output("r7_clear", 2'b00, 0, 0);

    // Flush wins over a same-cycle load issue.
    apply_stimulus(1, 0, 2'b00, 0, 0, 1, 1, 9, 2'd2);
    check_output("flush_long", 2'b00, 0, 0);
    apply_stimulus(1, 1, 2'b00, 0, 0, 1, 1, 10, 2'd1);
    check_output("flush_cycle", 2'b00, 0, 1);
    apply_stimulus(1, 0, 2'b11, 9, 10, 0, 0, 0, 2'd0);
    check_output("flush_after", 2'b00, 0, 0);

    // Disabled read port never flags.
    apply_stimulus(1, 0, 2'b00, 0, 0, 1, 1, 4, 2'd1);
    check_output("dis_load", 2'b00, 0, 0);
    apply_stimulus(1, 0, 2'b00, 4, 4, 1, 0, 0, 2'd0);
    check_output("dis_read", 2'b00, 0, 1);

    // Randomized traffic on a small register window, with occasional async reset.
    for (int k = 0; k < 3000; k++) begin
      apply_random(7);
      rst = ($urandom_range(0, 149) != 0);
    end
    rst = 1'b1;
    repeat (8) idle();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/id_hazard_scoreboard.md
Name: id_hazard_scoreboard

Overview:
- Parametrised successor to the fixed two-channel load-related stall logic in the decode stage.
- Tracks every in-flight register write whose result cannot yet be forwarded. Each tracked write carries its own remaining-latency counter.
- Drives per-read-port hazard flags and the decode-stage stall request for N read channels and three latency classes (ALU, load, long-op such as mult/div/CP0 read).
- Sits beside ID: consumes ID's decoded read/write register info and the pipeline-advance/flush controls, and replaces the external load_related inputs.

Parameters:
- REG_ADDR_WIDTH, 5, register address width; 2**REG_ADDR_WIDTH entries are tracked.
- NUM_READ_PORTS, 2, number of decode read channels checked.
- LOAD_LATENCY, 1, stall cycles owed by a consumer issued the cycle after a load.
- LONG_LATENCY, 4, stall cycles owed after a long-latency op.
- CNT_WIDTH, 3, counter width. Must satisfy 2**CNT_WIDTH > max(LOAD_LATENCY, LONG_LATENCY).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-low.
- pipe_advance  input  1  the stages after ID advance this cycle; 0 freezes the scoreboard.
- flush  input  1  exception/eret flush; squashes everything in flight.
- read_en  input  NUM_READ_PORTS  per-port read enable from ID.
- read_addr  input  NUM_READ_PORTS*REG_ADDR_WIDTH  packed read addresses; port i occupies bits [i*W +: W].
- issue_valid  input  1  ID holds a valid instruction this cycle.
- issue_write_en  input  1  that instruction writes a register.
- issue_write_addr  input  REG_ADDR_WIDTH  destination register.
- issue_lat_sel  input  2  latency class: 0 ALU (latency 0), 1 load, 2 long, 3 reserved (treated as ALU).
- read_related  output  NUM_READ_PORTS  per-port hazard flag.
- stall_request  output  1  OR of read_related.
- any_pending  output  1  at least one counter is nonzero.

Behaviour:
- State: one CNT_WIDTH counter per register. Register 0 is never tracked; its counter is permanently 0.
- Reset (rst low, asynchronous): all counters 0, so all outputs are 0 immediately. Reset asserted mid-operation discards all pending state.
- read_related[i] is combinational from the registered counters: read_en[i] && addr_i != 0 && cnt[addr_i] != 0. It uses pre-update counters.
- stall_request = |read_related. any_pending = OR over all counters != 0. Both combinational.
- Issue is accepted when: issue_valid && pipe_advance && !stall_request && !flush.
- Clock-edge update, in priority order:
  1. flush=1: all counters cleared. An issue in the same cycle is ignored, so flush wins.
  2. pipe_advance=0: all counters hold; no issue is accepted.
  3. pipe_advance=1: every nonzero counter decrements by 1. Then, if an issue is accepted with issue_write_en && issue_write_addr != 0, cnt[issue_write_addr] is set to the latency of its class. ALU class writes 0, which clears any older pending entry to the same register.
- Same-register rewrite: the new latency overrides the old count, so the youngest writer wins.
- Read of own destination register in the same instruction: checked against pre-update counters, so there is no self-hazard.
- Counters saturate at 0 (never wrap). LOAD_LATENCY or LONG_LATENCY of 0 is legal and disables that class's stall.
- Latency is zero cycles from counters to outputs. Stall cycles seen by a back-to-back consumer equal the class latency, given continuous pipe_advance.

Test Plan:
- Reset: hold rst low with random inputs → all outputs 0. Release, then issue load to r5, read r5 on port 0 next cycle → read_related=01, stall_request=1 for exactly 1 cycle, then 0.
- Long op: issue lat_sel=2 to r8, read r8 on port 1 next cycle → read_related=10 for 4 cycles. With pipe_advance forced low for 3 of those cycles, the stall lasts 7 cycles.
- Override: load r3 (cnt=1), then in the next cycle an accepted ALU write to r3 while a non-conflicting read proceeds → cnt[3]=0, and a read of r3 the following cycle does not stall. Separately, long write to r3 over a pending load → r3 read stalls 4 cycles.
- r0 and ports: load to r0, then read r0 on both ports → no stall, any_pending=0. Load r7, read r7 on port 1 only with port 0 enabled on r2 → read_related=10.
- Flush: issue long to r9, flush on the next cycle together with a valid load issue to r10 → all counters 0, any_pending=0, reads of r9 and r10 do not stall.
- Disabled read: load r4, next cycle read_addr=r4 with read_en=0 → no stall.
